// File: rtl/block_coeff_expand.sv
// Expands run/level words from a FWFT FIFO into 64 scan-ordered coefficients per 8x8 block.
// An EOB word zero-fills the rest of the block; malformed words raise a sticky error.
`ifndef INFO_BLOCK_CODE
`define INFO_BLOCK_CODE 14'h0001
`endif
`ifndef INFO_BLOCK_CODE_EOB
`define INFO_BLOCK_CODE_EOB 14'h0002
`endif

module block_coeff_expand (
  input  logic        clock,
  input  logic        resetn,
  input  logic        Start_I,
  output logic        Block_Done_O,
  output logic        Error_O,
  input  logic [31:0] Buffer_Value_I,
  input  logic        Buffer_Empty_I,
  output logic        Buffer_Read_En_O,
  input  logic        Hold_I,
  output logic [11:0] Coeff_Value_O,
  output logic [5:0]  Coeff_Index_O,
  output logic        Coeff_Write_En_O
);

  typedef enum logic [2:0] {IDLE, FETCH, ZERO_RUN, LEVEL, FILL, DONE} state_t;

  state_t      state_q;
  logic [6:0]  idx_q;
  logic [5:0]  run_q;
  logic [11:0] level_q;
  logic        done_q;
  logic        err_q;
  logic        we_q;
  logic [11:0] val_q;
  logic [5:0]  oidx_q;

  logic [13:0] info_d;
  logic [5:0]  run_d;
  logic [11:0] level_d;
  logic        idx_full_d;
  logic [6:0]  idx_inc_d;

  assign info_d     = Buffer_Value_I[31:18];
  assign run_d      = Buffer_Value_I[17:12];
  assign level_d    = Buffer_Value_I[11:0];
  // the index counter only ever reaches 64 through increments, so bit 6 marks "block full"
  assign idx_full_d = idx_q[6];
  assign idx_inc_d  = idx_q + 7'd1;

  assign Buffer_Read_En_O = (state_q == FETCH) && !Buffer_Empty_I && !Hold_I;

  assign Block_Done_O     = done_q;
  assign Error_O          = err_q;
  assign Coeff_Value_O    = val_q;
  assign Coeff_Index_O    = oidx_q;
  assign Coeff_Write_En_O = we_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= 7'd0;
      run_q   <= 6'd0;
      level_q <= 12'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      val_q   <= 12'd0;
      oidx_q  <= 6'd0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start_I) begin
            idx_q   <= 7'd0;
            err_q   <= 1'b0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (Buffer_Read_En_O) begin
            if (info_d == `INFO_BLOCK_CODE) begin
              if (idx_full_d) begin
                err_q <= 1'b1;
              end else begin
                run_q   <= run_d;
                level_q <= level_d;
                state_q <= (run_d != 6'd0) ? ZERO_RUN : LEVEL;
              end
            end else if (info_d == `INFO_BLOCK_CODE_EOB) begin
              if (idx_full_d) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= FILL;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ZERO_RUN: begin
          if (!Hold_I) begin
            if (idx_full_d) begin
              err_q   <= 1'b1;
              state_q <= FETCH;
            end else begin
              we_q    <= 1'b1;
              val_q   <= 12'd0;
              oidx_q  <= idx_q[5:0];
              idx_q   <= idx_inc_d;
              run_q   <= run_q - 6'd1;
              if (run_q == 6'd1) state_q <= LEVEL;
            end
          end
        end
        LEVEL: begin
          if (!Hold_I) begin
            if (idx_full_d) begin
              err_q <= 1'b1;
            end else begin
              we_q   <= 1'b1;
              val_q  <= level_q;
              oidx_q <= idx_q[5:0];
              idx_q  <= idx_inc_d;
            end
            state_q <= FETCH;
          end
        end
        FILL: begin
          if (!Hold_I) begin
            we_q   <= 1'b1;
            val_q  <= 12'd0;
            oidx_q <= idx_q[5:0];
            idx_q  <= idx_inc_d;
            if (idx_q == 7'd63) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_coeff_expand.sv
// Bench for block_coeff_expand: a FIFO model feeds directed word lists, and a block-image
// model built from the run/level rules checks every coefficient write and each done pulse.
`ifndef INFO_BLOCK_CODE
`define INFO_BLOCK_CODE 14'h0001
`endif
`ifndef INFO_BLOCK_CODE_EOB
`define INFO_BLOCK_CODE_EOB 14'h0002
`endif

module tb_block_coeff_expand;

  logic        clock;
  logic        resetn;
  logic        Start_I;
  logic        Block_Done_O;
  logic        Error_O;
  logic [31:0] Buffer_Value_I;
  logic        Buffer_Empty_I;
  logic        Buffer_Read_En_O;
  logic        Hold_I;
  logic [11:0] Coeff_Value_O;
  logic [5:0]  Coeff_Index_O;
  logic        Coeff_Write_En_O;

  block_coeff_expand dut (
    .clock            (clock),
    .resetn           (resetn),
    .Start_I          (Start_I),
    .Block_Done_O     (Block_Done_O),
    .Error_O          (Error_O),
    .Buffer_Value_I   (Buffer_Value_I),
    .Buffer_Empty_I   (Buffer_Empty_I),
    .Buffer_Read_En_O (Buffer_Read_En_O),
    .Hold_I           (Hold_I),
    .Coeff_Value_O    (Coeff_Value_O),
    .Coeff_Index_O    (Coeff_Index_O),
    .Coeff_Write_En_O (Coeff_Write_En_O)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [13:0] BLK = `INFO_BLOCK_CODE;
  localparam logic [13:0] EOB = `INFO_BLOCK_CODE_EOB;
  localparam logic [13:0] FOR = 14'h3FFF;

  int total = 0;
  int bad   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  logic [11:0] exp_img [64];
  logic [11:0] cap     [64];
  logic        exp_err;
  logic [31:0] fifo_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [13:0] c, input logic [5:0] r, input logic [11:0] l);
    return {c, r, l};
  endfunction

  // Expected block image: runs skip zero positions, a pair that cannot fit is an error.
  task automatic build_model(input logic [31:0] w[$]);
    int idx;
    int r;
    idx = 0;
    exp_err = 1'b0;
    for (int i = 0; i < 64; i++) exp_img[i] = 12'd0;
    foreach (w[k]) begin
      r = int'(w[k][17:12]);
      if (w[k][31:18] == BLK) begin
        if (idx >= 64) exp_err = 1'b1;
        else if (idx + r >= 64) begin
          exp_err = 1'b1;
          idx = 64;
        end else begin
          idx += r;
          exp_img[idx] = w[k][11:0];
          idx++;
        end
      end else if (w[k][31:18] == EOB) begin
        break;
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  always @(posedge clock) begin
    #2;
    if (Coeff_Write_En_O) begin
      check("wr_hold", Hold_I, 0);
      check("wr_idx", Coeff_Index_O, wr_cnt);
      check("wr_val", Coeff_Value_O, exp_img[Coeff_Index_O]);
      cap[Coeff_Index_O] = Coeff_Value_O;
      wr_cnt++;
    end
    if (Block_Done_O) begin
      check("done_writes", wr_cnt, 64);
      check("done_err", Error_O, exp_err);
      done_cnt++;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done"}, Block_Done_O, 0);
    check({tag, "_err"},  Error_O, 0);
    check({tag, "_rd"},   Buffer_Read_En_O, 0);
    check({tag, "_val"},  Coeff_Value_O, 0);
    check({tag, "_idx"},  Coeff_Index_O, 0);
    check({tag, "_we"},   Coeff_Write_En_O, 0);
  endtask

  task automatic mid_reset(input int rst_wr);
    resetn  = 1'b0;
    Start_I = 1'b0;
    Hold_I  = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    repeat (3) @(negedge clock);
    check_outputs_zero("rst_hold");
    resetn = 1'b1;
    Buffer_Empty_I = 1'b0;
    Buffer_Value_I = mk(BLK, 6'd0, 12'h111);
    repeat (10) begin
      @(negedge clock);
      check("rst_no_pop", Buffer_Read_En_O, 0);
    end
    check("rst_no_wr", wr_cnt, rst_wr);
    Buffer_Empty_I = 1'b1;
  endtask

  task automatic run_block(input logic [31:0] w[$], input int e_at, input int e_len,
                           input int h_at, input int h_len, input int s_at, input int rst_wr);
    bit pop_pend;
    bit aborted;
    int pops;
    pop_pend = 0;
    aborted  = 0;
    pops     = 0;
    build_model(w);
    fifo_q   = w;
    wr_cnt   = 0;
    done_cnt = 0;
    for (int i = 0; i < 64; i++) cap[i] = 12'hBAD;
    @(negedge clock);
    for (int cyc = 0; cyc < 400 && done_cnt == 0 && !aborted; cyc++) begin
      if (pop_pend && fifo_q.size() != 0) begin
        fifo_q.delete(0);
        pops++;
      end
      if (rst_wr >= 0 && wr_cnt == rst_wr) begin
        mid_reset(rst_wr);
        aborted = 1;
      end else begin
        if (cyc == 1) check("err_clr", Error_O, 0);
        Start_I        = (cyc == 0) || (cyc == s_at);
        Hold_I         = (cyc >= h_at) && (cyc < h_at + h_len);
        Buffer_Empty_I = (fifo_q.size() == 0) || ((cyc >= e_at) && (cyc < e_at + e_len));
        Buffer_Value_I = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEADBEEF;
        #1;
        check("rd_guard", Buffer_Read_En_O & (Buffer_Empty_I | Hold_I), 0);
        pop_pend = Buffer_Read_En_O;
        @(negedge clock);
      end
    end
    Start_I        = 1'b0;
    Hold_I         = 1'b0;
    Buffer_Empty_I = 1'b1;
    if (pop_pend && !aborted && fifo_q.size() != 0) begin
      fifo_q.delete(0);
      pops++;
    end
    if (!aborted) begin
      if (done_cnt == 0) begin
        total++;
        bad++;
        $display("FAIL done_timeout actual=no_done required=done_pulse t=%0t", $time);
      end else begin
        check("pops", pops, w.size());
        @(posedge clock);
        #2;
        check("done_width", Block_Done_O, 0);
      end
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [$];
    resetn         = 1'b1;
    Start_I        = 1'b0;
    Hold_I         = 1'b0;
    Buffer_Empty_I = 1'b1;
    Buffer_Value_I = 32'd0;
    #1 resetn = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    check_outputs_zero("rst_init");
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    w = '{mk(BLK, 6'd0, 12'h050), mk(EOB, 6'd0, 12'h000)};
    run_block(w, -1, 0, -1, 0, -1, -1);
    check("s1_c0", cap[0], 12'h050);
    check("s1_c1", cap[1], 12'h000);
    check("s1_err", Error_O, 0);

    w = '{mk(BLK, 6'd3, 12'hFFF), mk(EOB, 6'd0, 12'h000)};
    run_block(w, -1, 0, -1, 0, -1, -1);
    check("s2_c2", cap[2], 12'h000);
    check("s2_c3", cap[3], 12'hFFF);
    check("s2_c4", cap[4], 12'h000);

    w = '{mk(BLK, 6'd10, 12'h123), mk(EOB, 6'd0, 12'h000)};
    run_block(w, 1, 5, 10, 3, 20, -1);
    check("s3_c10", cap[10], 12'h123);
    check("s3_c9", cap[9], 12'h000);

    w = '{mk(BLK, 6'd63, 12'h001), mk(BLK, 6'd0, 12'h002), mk(EOB, 6'd0, 12'h000)};
    run_block(w, -1, 0, -1, 0, -1, -1);
    check("s4_c63", cap[63], 12'h001);
    check("s4_c0", cap[0], 12'h000);
    check("s4_err", Error_O, 1);

    w = '{mk(BLK, 6'd1, 12'h7AB), mk(FOR, 6'd5, 12'h333), mk(BLK, 6'd0, 12'h800), mk(EOB, 6'd0, 12'h000)};
    run_block(w, -1, 0, -1, 0, -1, -1);
    check("s5_c1", cap[1], 12'h7AB);
    check("s5_c2", cap[2], 12'h800);
    check("s5_c3", cap[3], 12'h000);
    check("s5_err", Error_O, 1);

    w = '{mk(BLK, 6'd60, 12'h005), mk(BLK, 6'd10, 12'h006), mk(EOB, 6'd0, 12'h000)};
    run_block(w, -1, 0, -1, 0, -1, -1);
    check("s6_c60", cap[60], 12'h005);
    check("s6_c63", cap[63], 12'h000);
    check("s6_err", Error_O, 1);

    w = '{mk(BLK, 6'd40, 12'h0AA), mk(EOB, 6'd0, 12'h000)};
    run_block(w, -1, 0, -1, 0, -1, 20);

    w = '{mk(BLK, 6'd0, 12'h050), mk(EOB, 6'd0, 12'h000)};
    run_block(w, -1, 0, -1, 0, -1, -1);
    check("s7_c0", cap[0], 12'h050);
    check("s7_err", Error_O, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
